// File: rtl/apple_bus_host_if.sv
// Command/response port of the Apple slot-bus host.
// master = command issuer, slave = the bus host.
interface apple_bus_host_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;

   modport master (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/apple_bus_host.sv
// Apple II slot-bus host: one 24-clock bus cycle per command, PHI0 high for the second half.
// Define APPLE_BUS_RDY_WAIT_EN to honour card nRDY wait requests on read cycles.
module apple_bus_host #(
   parameter logic [2:0] SLOT = 3'd1
) (
   input  logic            C25M,
   input  logic            nRES,
   apple_bus_host_if.slave host,
   output logic            PHI0,
   output logic [15:0]     RA,
   output logic            nWE,
   inout  wire  [7:0]      RD,
   output logic            nDEVSEL,
   output logic            nIOSEL,
   output logic            nIOSTRB,
   input  logic            nRDY,
   output logic            nRESout
);
   typedef enum logic [1:0] {CYC_IDLE, CYC_READ, CYC_WRITE} cyc_t;

   cyc_t        cycState, cycNext;
   logic [4:0]  bc;
   logic [3:0]  rstCnt;
   logic [15:0] raNext;
   logic [7:0]  wrData, pendData;
   logic        lastBc, accept, endCycle, repeatPending, timeoutErr;
   logic        rdOe, pendRsp, pendErr;
   logic        devHit, ioHit, strbHit;

   assign lastBc         = (bc == 5'd23);
   assign PHI0           = (bc >= 5'd12);
   assign host.cmd_ready = lastBc && nRESout && !repeatPending;
   assign accept         = host.cmd_ready && host.cmd_valid;
   assign endCycle       = lastBc && (cycState != CYC_IDLE) && !repeatPending;
   assign nWE            = (cycState != CYC_WRITE);
   assign RD             = rdOe ? wrData : 8'hzz;

   assign devHit  = (RA[15:4]  == {8'hC0, 1'b1, SLOT});
   assign ioHit   = (RA[15:8]  == {5'b11000, SLOT});
   assign strbHit = (RA[15:11] == 5'b11001);

   // Bus-cycle counter and the card reset hold of 16 full bus cycles.
   always_ff @(posedge C25M or negedge nRES) begin
      if (!nRES) begin
         bc      <= '0;
         rstCnt  <= '0;
         nRESout <= 1'b0;
      end else begin
         bc <= lastBc ? 5'd0 : bc + 5'd1;
         if (lastBc && !nRESout) begin
            rstCnt <= rstCnt + 4'd1;
            if (rstCnt == 4'd15) nRESout <= 1'b1;
         end
      end
   end

   // Cycle ownership only changes at the 23->0 boundary; a repeat keeps everything.
   always_comb begin
      cycNext = cycState;
      raNext  = RA;
      if (lastBc && !repeatPending) begin
         if (accept) begin
            cycNext = host.cmd_wr ? CYC_WRITE : CYC_READ;
            raNext  = host.cmd_addr;
         end else begin
            cycNext = CYC_IDLE;
            raNext  = 16'h0000;
         end
      end
   end

   always_ff @(posedge C25M or negedge nRES) begin
      if (!nRES) begin
         cycState <= CYC_IDLE;
         RA       <= '0;
         wrData   <= '0;
      end else begin
         cycState <= cycNext;
         RA       <= raNext;
         if (accept) wrData <= host.cmd_wdata;
      end
   end

   always_ff @(posedge C25M or negedge nRES) begin
      if (!nRES) begin
         nDEVSEL <= 1'b1;
         nIOSEL  <= 1'b1;
         nIOSTRB <= 1'b1;
         rdOe    <= 1'b0;
      end else begin
         if (bc == 5'd11) begin
            nDEVSEL <= !devHit;
            nIOSEL  <= !ioHit;
            nIOSTRB <= !strbHit;
         end else if (lastBc) begin
            nDEVSEL <= 1'b1;
            nIOSEL  <= 1'b1;
            nIOSTRB <= 1'b1;
         end
         if (bc == 5'd1 && cycState == CYC_WRITE) rdOe <= 1'b1;
         else if (lastBc)                         rdOe <= 1'b0;
      end
   end

   // Result is latched as the cycle ends and presented one clock later.
   always_ff @(posedge C25M or negedge nRES) begin
      if (!nRES) begin
         pendRsp        <= 1'b0;
         pendData       <= '0;
         pendErr        <= 1'b0;
         host.rsp_valid <= 1'b0;
         host.rsp_rdata <= '0;
         host.rsp_err   <= 1'b0;
      end else begin
         host.rsp_valid <= 1'b0;
         if (endCycle) begin
            pendRsp  <= 1'b1;
            pendData <= (cycState == CYC_READ) ? RD : 8'h00;
            pendErr  <= timeoutErr;
         end else if (pendRsp) begin
            pendRsp        <= 1'b0;
            host.rsp_valid <= 1'b1;
            host.rsp_rdata <= pendData;
            host.rsp_err   <= pendErr;
         end
      end
   end

`ifdef APPLE_BUS_RDY_WAIT_EN
   logic       rdyLow;
   logic [3:0] repCnt;

   // repCnt counts repeats already run; the 16th low sample gives up with an error.
   assign repeatPending = rdyLow && (repCnt != 4'd15);
   assign timeoutErr    = rdyLow && (repCnt == 4'd15);

   always_ff @(posedge C25M or negedge nRES) begin
      if (!nRES) begin
         rdyLow <= 1'b0;
         repCnt <= '0;
      end else if (bc == 5'd22 && cycState == CYC_READ) begin
         rdyLow <= !nRDY;
      end else if (lastBc) begin
         rdyLow <= 1'b0;
         repCnt <= repeatPending ? repCnt + 4'd1 : 4'd0;
      end
   end
`else
   logic unusedRdy;
   assign unusedRdy     = nRDY;
   assign repeatPending = 1'b0;
   assign timeoutErr    = 1'b0;
`endif
endmodule

// File: tb/tb_apple_bus_host.sv
// Scoreboard bench for apple_bus_host (SLOT=3) with a simple read-data card model.
module tb_apple_bus_host;
   typedef struct {
      logic [7:0] data;
      logic       err;
      int         lat;
      int         acc;
   } exp_t;

   logic        C25M = 1'b0;
   logic        nRES = 1'b1;
   logic        PHI0, nWE, nDEVSEL, nIOSEL, nIOSTRB, nRDY, nRESout;
   logic [15:0] RA;
   wire  [7:0]  RD;
   logic [7:0]  modelData = 8'h00;
   logic        modelDrv;
   int          cyc = 0, phiFalls = 0, rdyUntil = 0;
   int          nChk = 0, nFail = 0, rspCnt = 0;
   exp_t        sb[$];

   apple_bus_host_if hostIf();

   apple_bus_host #(.SLOT(3'd3)) dut (
      .C25M(C25M), .nRES(nRES), .host(hostIf), .PHI0(PHI0), .RA(RA), .nWE(nWE),
      .RD(RD), .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB),
      .nRDY(nRDY), .nRESout(nRESout)
   );

   always #20 C25M = ~C25M;
   always @(posedge C25M) cyc <= cyc + 1;
   always @(negedge PHI0) phiFalls <= phiFalls + 1;

   // Card model: drives read data while PHI0 is high; bus floats high otherwise.
   genvar gi;
   for (gi = 0; gi < 8; gi++) begin : gPull
      pullup pu (RD[gi]);
   end
   assign modelDrv = PHI0 && nWE && (RA != 16'h0000);
   assign RD       = modelDrv ? modelData : 8'hzz;
   assign nRDY     = (phiFalls >= rdyUntil);

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nChk++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   task automatic waitNeg(input int n);
      repeat (n) @(negedge C25M);
   endtask

   // Returns at the falling edge just after the accepting edge (BC==0 of the owned cycle).
   task automatic sendCmd(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                          input logic [7:0] eData, input logic eErr, input int eLat,
                          input bit eRsp, output int acc);
      int   t = 0;
      exp_t e;
      hostIf.cmd_valid = 1'b1;
      hostIf.cmd_wr    = wr;
      hostIf.cmd_addr  = addr;
      hostIf.cmd_wdata = wd;
      while (!hostIf.cmd_ready && t < 2000) begin
         @(negedge C25M);
         t++;
      end
      chk("acceptWait", {31'd0, hostIf.cmd_ready}, 32'd1);
      acc = cyc + 1;
      if (eRsp) begin
         e.data = eData; e.err = eErr; e.lat = eLat; e.acc = acc;
         sb.push_back(e);
      end
      @(negedge C25M);
      hostIf.cmd_valid = 1'b0;
   endtask

   task automatic waitRsp();
      int t = 0;
      while (sb.size() != 0 && t < 1000) begin
         @(negedge C25M);
         t++;
      end
      chk("sbDrain", sb.size(), 0);
   endtask

   always @(negedge C25M) begin : mon
      exp_t e;
      if (hostIf.rsp_valid) begin
         rspCnt++;
         if (sb.size() == 0) chk("unexpRsp", 1, 0);
         else begin
            e = sb.pop_front();
            chk("rspData", hostIf.rsp_rdata, e.data);
            chk("rspErr", hostIf.rsp_err, e.err);
            chk("rspLat", cyc - e.acc, e.lat);
         end
      end
   end

   initial begin
      int n, a1, a2, a3, rspBefore;
      bit early;
      hostIf.cmd_valid = 1'b0;
      hostIf.cmd_wr    = 1'b0;
      hostIf.cmd_addr  = '0;
      hostIf.cmd_wdata = '0;
      #5 nRES = 1'b0;
      waitNeg(3);
      chk("rstPhi0", PHI0, 0);
      chk("rstRA", RA, 16'h0000);
      chk("rstNWE", nWE, 1);
      chk("rstSel", {nDEVSEL, nIOSEL, nIOSTRB}, 3'b111);
      chk("rstRD", RD, 8'hFF);
      chk("rstReady", hostIf.cmd_ready, 0);
      chk("rstRsp", {hostIf.rsp_valid, hostIf.rsp_err, hostIf.rsp_rdata}, 0);
      chk("rstNRESout", nRESout, 0);

      nRES = 1'b1;
      n = 0; early = 0;
      while (!nRESout && n < 1000) begin
         @(negedge C25M);
         n++;
         if (hostIf.cmd_ready && !nRESout) early = 1;
      end
      chk("nresoutDly", n, 384);
      chk("earlyReady", early, 0);
      n = 0;
      while (!hostIf.cmd_ready && n < 100) begin
         @(negedge C25M);
         n++;
      end
      chk("firstReady", n, 23);

      // Write to device-select space of slot 3
      sendCmd(1'b1, 16'hC0B3, 8'h5A, 8'h00, 1'b0, 25, 1'b1, a1);
      chk("wrRA", RA, 16'hC0B3);
      chk("wrNWE", nWE, 0);
      chk("wrRDbc0", RD, 8'hFF);
      waitNeg(2);
      chk("wrRDbc2", RD, 8'h5A);
      waitNeg(9);
      chk("wrSelBc11", {PHI0, nDEVSEL, nIOSEL, nIOSTRB}, 4'b0111);
      waitNeg(1);
      chk("wrSelBc12", {PHI0, nDEVSEL, nIOSEL, nIOSTRB}, 4'b1011);
      waitNeg(11);
      chk("wrSelBc23", {nDEVSEL, nIOSEL, nIOSTRB}, 3'b011);
      chk("wrRDbc23", RD, 8'h5A);
      waitNeg(1);
      chk("idleSel", {nDEVSEL, nIOSEL, nIOSTRB}, 3'b111);
      chk("idleBus", {RA, nWE}, {16'h0000, 1'b1});
      chk("idleRD", RD, 8'hFF);
      waitRsp();

      modelData = 8'hA5;
      sendCmd(1'b0, 16'hC3FF, 8'h00, 8'hA5, 1'b0, 25, 1'b1, a1);
      waitNeg(12);
      chk("ioSel", {nWE, nDEVSEL, nIOSEL, nIOSTRB}, 4'b1101);
      waitRsp();

      modelData = 8'h3C;
      sendCmd(1'b0, 16'hC800, 8'h00, 8'h3C, 1'b0, 25, 1'b1, a1);
      waitNeg(12);
      chk("strbSel", {nDEVSEL, nIOSEL, nIOSTRB}, 3'b110);
      waitRsp();

`ifdef APPLE_BUS_RDY_WAIT_EN
      modelData = 8'hC4;
      sendCmd(1'b0, 16'hC3FF, 8'h00, 8'hC4, 1'b0, 73, 1'b1, a1);
      rdyUntil = phiFalls + 2;
      waitRsp();
      sendCmd(1'b0, 16'hC3FF, 8'h00, 8'hC4, 1'b1, 385, 1'b1, a1);
      rdyUntil = phiFalls + 100;
      waitRsp();
      rdyUntil = phiFalls;
      modelData = 8'h5C;
      sendCmd(1'b0, 16'hC0B5, 8'h00, 8'h5C, 1'b0, 25, 1'b1, a1);
      waitRsp();
`else
      modelData = 8'h5C;
      rdyUntil = phiFalls + 100;
      sendCmd(1'b0, 16'hC0B5, 8'h00, 8'h5C, 1'b0, 25, 1'b1, a1);
      waitRsp();
      rdyUntil = phiFalls;
`endif

      // Back-to-back: write, read, write
      modelData = 8'h77;
      sendCmd(1'b1, 16'hC0B0, 8'h11, 8'h00, 1'b0, 25, 1'b1, a1);
      sendCmd(1'b0, 16'hC300, 8'h00, 8'h77, 1'b0, 25, 1'b1, a2);
      sendCmd(1'b1, 16'h1234, 8'h22, 8'h00, 1'b0, 25, 1'b1, a3);
      chk("b2bGap1", a2 - a1, 24);
      chk("b2bGap2", a3 - a2, 24);
      waitRsp();

      // Reset in the middle of a write
      rspBefore = rspCnt;
      sendCmd(1'b1, 16'hC0B3, 8'h5A, 8'h00, 1'b0, 25, 1'b0, a1);
      waitNeg(15);
      chk("midSelPre", {nDEVSEL, nIOSEL, nIOSTRB}, 3'b011);
      chk("midRDPre", RD, 8'h5A);
      #5 nRES = 1'b0;
      #1;
      chk("midRD", RD, 8'hFF);
      chk("midSel", {nDEVSEL, nIOSEL, nIOSTRB}, 3'b111);
      chk("midBus", {RA, nWE, nRESout}, {16'h0000, 1'b1, 1'b0});
      waitNeg(3);
      nRES = 1'b1;
      waitNeg(60);
      chk("midNoRsp", rspCnt, rspBefore);
      chk("sbEmpty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
      $finish;
   end
endmodule

// File: doc/apple_bus_host.md
APPLE_BUS_HOST -- requirements
Module: apple_bus_host

Interface
REQ-001 The block SHALL have one clock C25M (25 MHz) and one asynchronous, active-low reset nRES; all state SHALL be clocked on posedge C25M and cleared on negedge nRES.
REQ-002 Parameter: SLOT, default 3'd1, the Apple slot number (1-7) the host decodes selects for.
REQ-003 C25M  input  1  system clock.
REQ-004 nRES  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  command request; cmd_ready  output  1  command accepted when both are high on one edge.
REQ-006 cmd_wr  input  1  1 = write cycle, 0 = read cycle; cmd_addr  input  16  bus address; cmd_wdata  input  8  write data.
REQ-007 rsp_valid  output  1  one-cycle completion pulse; rsp_rdata  output  8  read data; rsp_err  output  1  RDY timeout flag.
REQ-008 PHI0  output  1  generated bus clock; RA  output  16  address; nWE  output  1  write strobe, active low.
REQ-009 RD  inout  8  data bus; nDEVSEL, nIOSEL, nIOSTRB  output  1 each  slot selects, active low.
REQ-010 nRDY  input  1  card wait request, active low; nRESout  output  1  card reset, active low.

Function
REQ-011 A bus-cycle counter BC SHALL count 0..23 and wrap to 0 continuously; PHI0 SHALL be 0 for BC 0-11 and 1 for BC 12-23.
REQ-012 cmd_ready SHALL be high only while BC==23, nRESout==1, and no repeat is pending; a command accepted at that edge owns the bus cycle starting at BC==0.
REQ-013 RA and nWE SHALL update only on the 23->0 edge; with no accepted command the cycle is idle: RA=16'h0000, nWE=1, all selects high, RD released.
REQ-014 nDEVSEL SHALL go low on the 11->12 edge and high on the 23->0 edge when RA[15:4]=={8'hC0, 1'b1, SLOT}.
REQ-015 nIOSEL SHALL be asserted with the same timing when RA[15:8]=={5'b11000, SLOT}.
REQ-016 nIOSTRB SHALL be asserted with the same timing when RA[15:11]==5'b11001.
REQ-017 Write cycles SHALL drive RD=cmd_wdata from the 1->2 edge until the 23->0 edge; RD SHALL be high-impedance at all other times and in all read/idle cycles.
REQ-018 Read cycles SHALL capture RD on the 23->0 edge ending the cycle.
REQ-019 rsp_valid SHALL pulse for exactly one C25M cycle, on the edge after the owned cycle ends, for reads and writes.
REQ-020 The accept-to-rsp_valid latency SHALL be 25 C25M cycles, or 25+24*N with N RDY repeats.
REQ-021 rsp_rdata SHALL hold the captured byte for reads and 8'h00 for writes until the next rsp_valid.
REQ-022 Back-to-back commands SHALL run in consecutive bus cycles with no idle cycle between them.
REQ-023 cmd_valid deasserted at BC==23 SHALL yield an idle cycle; cmd_* inputs are ignored when cmd_ready==0.

Reset
REQ-024 On nRES low: BC=0, PHI0=0, RA=16'h0000, nWE=1, all selects=1, RD released, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, nRESout=0, repeat counter=0.
REQ-025 After nRES deassertion, nRESout SHALL stay low for 16 complete bus cycles, then go high on a 23->0 edge; no command is accepted before then.
REQ-026 An in-flight cycle interrupted by reset SHALL be discarded with no rsp_valid.

Configuration
REQ-027 Macro APPLE_BUS_RDY_WAIT_EN, when defined: nRDY is sampled on the 22->23 edge of read cycles only.
REQ-028 With the macro defined, if sampled nRDY==0 the cycle SHALL repeat with identical RA/nWE/selects and no rsp_valid, up to 15 repeats.
REQ-029 With the macro defined, a 16th consecutive nRDY==0 SHALL end the command with rsp_valid=1, rsp_err=1, and the last captured data.
REQ-030 With the macro undefined, nRDY SHALL be ignored, no cycle repeats, and rsp_err SHALL always be 0.

Verification
REQ-031 Release nRES -> nRESout rises after 384 C25M cycles (16x24); cmd_ready first asserts at the following BC==23.
REQ-032 Write cmd_addr=16'hC0B3, SLOT=3, cmd_wdata=8'h5A -> nDEVSEL low for BC 12-23, nWE=0, RD=8'h5A, nIOSEL/nIOSTRB high, rsp_valid 25 cycles after accept.
REQ-033 Read cmd_addr=16'hC3FF with the model driving 8'hA5 during PHI0 high -> nIOSEL low, rsp_rdata=8'hA5; read 16'hC800 -> nIOSTRB low only.
REQ-034 Three back-to-back commands with cmd_valid held high -> three consecutive bus cycles, three rsp_valid pulses exactly 24 cycles apart.
REQ-035 With APPLE_BUS_RDY_WAIT_EN defined: nRDY low for 2 read cycles -> rsp after 73 cycles, rsp_err=0; nRDY held low -> rsp_err=1 after 16 cycles.
REQ-036 Assert nRES at BC==15 of a write -> RD goes high-impedance and selects go high immediately, and no rsp_valid occurs.
